// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode/funct, ALU and mux-select encodings for the multicycle control unit
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, JMP
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_ADDU = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
endpackage

// File: rtl/mc_control_alu_dec.sv
// alu_dec: maps funct (R-type) or opcode (I-type/beq) to the 3-bit ALU operation and flags valid functs
module alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_ok
);
    logic [2:0] r_ctrl;

    always_comb begin
        funct_ok = 1'b1;
        r_ctrl   = ALU_ADD;
        case (funct)
            FN_ADD:  r_ctrl = ALU_ADD;
            FN_ADDU: r_ctrl = ALU_ADDU;
            FN_SUB:  r_ctrl = ALU_SUB;
            FN_AND:  r_ctrl = ALU_AND;
            FN_OR:   r_ctrl = ALU_OR;
            FN_NOR:  r_ctrl = ALU_NOR;
            default: funct_ok = 1'b0;
        endcase
    end

    assign alu_ctrl = opcode == OP_R    ? r_ctrl :
                      opcode == OP_ANDI ? ALU_AND :
                      opcode == OP_ORI  ? ALU_OR :
                      opcode == OP_BEQ  ? ALU_SUB : ALU_ADD;
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM sequencing fetch, decode, execute, memory and writeback
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       O,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ExtOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUCtrl,
    output logic       ovf,
    output logic       illegal
);
    state_t     state;
    logic       ovf_q;
    logic [2:0] dec_alu;
    logic       funct_ok;
    logic       is_r, is_mem, is_imm, legal;
    logic       unused_zero;

    // the branch decision on Zero is made in the datapath
    assign unused_zero = Zero;

    alu_dec u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (dec_alu),
        .funct_ok (funct_ok)
    );

    assign is_r   = opcode == OP_R;
    assign is_mem = opcode == OP_LW || opcode == OP_SW;
    assign is_imm = opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI;
    assign legal  = is_r ? funct_ok : is_mem || is_imm || opcode == OP_BEQ || opcode == OP_J;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= O && ((state == REX && (funct == FN_ADD || funct == FN_SUB)) ||
                           (state == IEX && opcode == OP_ADDI));
            case (state)
                FETCH:   state <= mem_rdy ? DECODE : FETCH;
                DECODE:  state <= !legal ? FETCH : is_mem ? MEMADR : is_r ? REX :
                                  is_imm ? IEX : opcode == OP_BEQ ? BEQ : JMP;
                MEMADR:  state <= opcode == OP_LW ? MEMRD : MEMWR;
                MEMRD:   state <= mem_rdy ? MEMWB : MEMRD;
                MEMWR:   state <= mem_rdy ? FETCH : MEMWR;
                REX:     state <= RWB;
                IEX:     state <= IWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
         RegWrite, ALUSrcA, ExtOp, ALUSrcB, PCSource, ovf, illegal} = '0;
        ALUCtrl = ALU_ADD;
        case (state)
            FETCH:   begin MemRead = 1'b1; ALUSrcB = SRCB_FOUR; IRWrite = mem_rdy; PCWrite = mem_rdy; end
            DECODE:  begin ALUSrcB = SRCB_BR; ExtOp = 1'b1; illegal = !legal; end
            MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; ExtOp = 1'b1; end
            MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
            MEMWB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
            REX:     begin ALUSrcA = 1'b1; ALUSrcB = SRCB_REG; ALUCtrl = dec_alu; end
            RWB:     begin RegDst = 1'b1; RegWrite = !ovf_q; ovf = ovf_q; ALUCtrl = dec_alu; end
            IEX:     begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; ALUCtrl = dec_alu; ExtOp = opcode == OP_ADDI; end
            IWB:     begin RegWrite = !ovf_q; ovf = ovf_q; end
            BEQ:     begin ALUSrcA = 1'b1; ALUSrcB = SRCB_REG; ALUCtrl = ALU_SUB; PCWriteCond = 1'b1; PCSource = PCS_OUT; end
            JMP:     begin PCWrite = 1'b1; PCSource = PCS_JMP; end
            default: ;
        endcase
        // reset kills any in-flight write on the same cycle it rises
        if (rst) begin
            {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ExtOp, ALUSrcB, PCSource, ovf, illegal} = '0;
            ALUCtrl = 3'b000;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized scoreboard bench; expected per-cycle control words come from an instruction-level model
module tb_mc_control;
    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ext;
        logic [1:0] srcb, pcs;
        logic [2:0] alu;
        logic ovf, ill;
    } ctl_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                           J = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010,
                           F_AND = 6'b100100, F_OR = 6'b100101, F_NOR = 6'b100111;

    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic Zero = 1'b0, O = 1'b0, mem_rdy = 1'b0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUCtrl;
    logic ovf, illegal;

    ctl_t act, exp_c;
    ctl_t q[$];
    string nq[$];
    string nm;
    int checks = 0, passed = 0;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero), .O(O), .mem_rdy(mem_rdy),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ExtOp(ExtOp), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUCtrl(ALUCtrl), .ovf(ovf), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                  ALUSrcA, ExtOp, ALUSrcB, PCSource, ALUCtrl, ovf, illegal};

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_c = q.pop_front();
            nm = nq.pop_front();
            checks++;
            if (act === exp_c) passed++;
            else $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp_c);
        end
    end

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.alu = 3'b100;
        return c;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            F_ADDU:  return 3'b101;
            F_SUB:   return 3'b110;
            F_AND:   return 3'b000;
            F_OR:    return 3'b001;
            F_NOR:   return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            LW:             return 1;
            SW:             return 2;
            R:              return (fn inside {F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR}) ? 3 : 0;
            ADDI, ANDI, ORI: return 4;
            BEQ:            return 5;
            J:              return 6;
            default:        return 0;
        endcase
    endfunction

    task automatic step(input ctl_t e, input string n, input logic rdy, input logic o);
        mem_rdy = rdy;
        O = o;
        Zero = 1'($urandom);
        q.push_back(e);
        nq.push_back(n);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic o_ex, input int wf, input int wm);
        ctl_t c;
        int k;
        logic ov;
        opcode = op;
        funct = fn;
        k = kind(op, fn);
        for (int i = 0; i <= wf; i++) begin
            c = idle(); c.mrd = 1; c.srcb = 2'b01; c.irw = (i == wf); c.pcw = (i == wf);
            step(c, "fetch", i == wf, rb());
        end
        c = idle(); c.srcb = 2'b11; c.ext = 1; c.ill = (k == 0);
        step(c, "decode", rb(), rb());
        case (k)
            1, 2: begin
                c = idle(); c.srca = 1; c.srcb = 2'b10; c.ext = 1;
                step(c, "memadr", rb(), rb());
                for (int i = 0; i <= wm; i++) begin
                    c = idle(); c.iord = 1; c.mrd = (k == 1); c.mwr = (k == 2);
                    step(c, k == 1 ? "memrd" : "memwr", i == wm, rb());
                end
                checks++;
                if (k == 1 ? (RegWrite === 1'b1 && MemtoReg === 1'b1 && MemRead === 1'b0)
                           : (MemRead === 1'b1 && MemWrite === 1'b0)) passed++;
                else $display("FAIL wait_expired @%0t: state did not advance after mem_rdy", $time);
                if (k == 1) begin
                    c = idle(); c.rw = 1; c.m2r = 1;
                    step(c, "memwb", rb(), rb());
                end
            end
            3: begin
                ov = o_ex && (fn == F_ADD || fn == F_SUB);
                c = idle(); c.srca = 1; c.alu = r_alu(fn);
                step(c, "rex", rb(), o_ex);
                c = idle(); c.rdst = 1; c.rw = !ov; c.ovf = ov; c.alu = r_alu(fn);
                step(c, "rwb", rb(), rb());
            end
            4: begin
                ov = o_ex && op == ADDI;
                c = idle(); c.srca = 1; c.srcb = 2'b10; c.ext = (op == ADDI);
                c.alu = op == ANDI ? 3'b000 : op == ORI ? 3'b001 : 3'b100;
                step(c, "iex", rb(), o_ex);
                c = idle(); c.rw = !ov; c.ovf = ov;
                step(c, "iwb", rb(), rb());
            end
            5: begin
                c = idle(); c.srca = 1; c.alu = 3'b110; c.pcwc = 1; c.pcs = 2'b01;
                step(c, "beq", rb(), rb());
            end
            6: begin
                c = idle(); c.pcw = 1; c.pcs = 2'b10;
                step(c, "jmp", rb(), rb());
            end
            default: ;
        endcase
    endtask

    logic [5:0] ops[8] = '{R, LW, SW, BEQ, J, ADDI, ANDI, ORI};
    logic [5:0] fns[6] = '{F_ADD, F_ADDU, F_SUB, F_AND, F_OR, F_NOR};

    initial begin
        ctl_t c;
        logic [5:0] op, fn;
        @(posedge clk);
        #1;
        step('0, "reset", 1, 1);
        step('0, "reset", 1, 1);
        rst = 0;
        run(LW, 6'd0, 0, 0, 0);
        run(SW, 6'd0, 0, 0, 2);
        run(R, F_ADD, 1, 0, 0);
        run(R, F_ADDU, 1, 0, 0);
        run(R, F_SUB, 1, 1, 0);
        run(R, F_NOR, 1, 0, 0);
        run(BEQ, 6'd0, 0, 0, 0);
        run(J, 6'd0, 0, 0, 0);
        run(6'b111111, 6'd0, 0, 0, 0);
        run(R, 6'b101010, 0, 0, 0);
        run(ADDI, 6'd0, 1, 0, 0);
        run(ANDI, 6'd0, 1, 0, 0);
        run(ORI, 6'd0, 1, 0, 0);
        run(LW, 6'd0, 0, 2, 3);
        opcode = SW;
        c = idle(); c.mrd = 1; c.srcb = 2'b01; c.irw = 1; c.pcw = 1;
        step(c, "fetch", 1, 0);
        c = idle(); c.srcb = 2'b11; c.ext = 1;
        step(c, "decode", 0, 0);
        c = idle(); c.srca = 1; c.srcb = 2'b10; c.ext = 1;
        step(c, "memadr", 0, 0);
        c = idle(); c.iord = 1; c.mwr = 1;
        step(c, "memwr", 0, 0);
        rst = 1;
        #1;
        checks++;
        if (act === '0 && MemWrite === 1'b0) passed++;
        else $display("FAIL reset_state @%0t: got %h want 0", $time, act);
        step('0, "rst_memwr", 1, 0);
        rst = 0;
        run(J, 6'd0, 0, 0, 0);
        for (int n = 0; n < 250; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
            run(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
